// File: rtl/filt_coef_loader_if.sv
// Read side of the CPU coefficient FIFO, as seen from the filter clock domain.
// The loader is the master: it issues pops and consumes the flag and data.
interface filt_coef_loader_if #(
  parameter int WIDTH = 24,
  parameter int AW    = 3
);
  logic                fifo_rd_empty;
  logic [AW+WIDTH-1:0] fifo_dout;
  logic                fifo_rd_en;

  modport master (
    input  fifo_rd_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_rd_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/filt_coef_loader.sv
// Pops {addr, coef} words into a shadow bank and commits the full bank to the
// active bank on a sample boundary, so the filter never sees mixed taps.
//
// state  | meaning
// IDLE   | pop a word if the FIFO has one
// CAPT   | popped word is on fifo_dout; write it to shadow, update mask
// PEND   | all 8 shadow entries written; hold off the FIFO until a strobe
// COMMIT | copy shadow -> active, clear mask, pulse coef_update
module filt_coef_loader #(
  parameter int WIDTH = 24,
  parameter int AW    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  filt_coef_loader_if.master      fifo,
  input  logic                    sample_strobe,
  input  logic [AW-1:0]           coef_rd_addr,
  output logic [WIDTH-1:0]        coef_rd_data,
  output logic                    coef_valid,
  output logic                    coef_update,
  output logic                    load_busy
);

  localparam int NCOEF = 2**AW;

  typedef enum logic [1:0] {IDLE, CAPT, PEND, COMMIT} state_t;

  state_t             state;
  logic [WIDTH-1:0]   shadow [NCOEF];
  logic [WIDTH-1:0]   active [NCOEF];
  logic [NCOEF-1:0]   mask;
  logic [NCOEF-1:0]   mask_next;
  logic [AW-1:0]      cap_addr;
  logic [WIDTH-1:0]   cap_data;

  assign cap_addr = fifo.fifo_dout[AW+WIDTH-1:WIDTH];
  assign cap_data = fifo.fifo_dout[WIDTH-1:0];

  always_comb begin
    mask_next = mask | (NCOEF'(1) << cap_addr);
  end

  // Pop only from IDLE so the 1-cycle read latency lines up with CAPT.
  assign fifo.fifo_rd_en = (state == IDLE) && !fifo.fifo_rd_empty && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      coef_valid  <= 1'b0;
      coef_update <= 1'b0;
      for (int i = 0; i < NCOEF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      coef_update <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo.fifo_rd_empty) state <= CAPT;
        end
        CAPT: begin
          shadow[cap_addr] <= cap_data;
          mask             <= mask_next;
          state            <= (&mask_next) ? PEND : IDLE;
        end
        PEND: begin
          if (sample_strobe) begin
            state       <= COMMIT;
            coef_update <= 1'b1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NCOEF; i++) active[i] <= shadow[i];
          mask       <= '0;
          coef_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign coef_rd_data = active[coef_rd_addr];
  assign load_busy    = (mask != '0) || (state != IDLE);

endmodule

// File: tb/tb_filt_coef_loader.sv
// Bench for filt_coef_loader: a FIFO model feeds words, a word-order reference
// model predicts each committed bank, and a monitor checks every commit.
`timescale 1ns/1ps
module tb_filt_coef_loader;
  localparam int WIDTH = 24;
  localparam int AW    = 3;

  typedef logic [7:0][23:0] bank_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_strobe = 1'b0;
  logic [2:0]  coef_rd_addr;
  logic [2:0]  probe_addr = 3'd0;
  logic [2:0]  sweep_addr = 3'd0;
  logic        sweeping = 1'b0;
  logic [23:0] coef_rd_data;
  logic        coef_valid, coef_update, load_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  filt_coef_loader_if #(.WIDTH(WIDTH), .AW(AW)) ff ();

  assign coef_rd_addr = sweeping ? sweep_addr : probe_addr;

  filt_coef_loader #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo          (ff),
    .sample_strobe (sample_strobe),
    .coef_rd_addr  (coef_rd_addr),
    .coef_rd_data  (coef_rd_data),
    .coef_valid    (coef_valid),
    .coef_update   (coef_update),
    .load_busy     (load_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model with 1-cycle read latency
  logic [26:0] fbuf [0:1023];
  int n_push = 0;
  int n_pop  = 0;
  bit prev_pop = 1'b0;
  assign ff.fifo_rd_empty = (n_push == n_pop);

  always @(posedge clk) begin
    if (ff.fifo_rd_en) begin
      chk("rd_en_while_nonempty", 32'(n_push != n_pop), 1);
      chk("rd_en_not_back_to_back", 32'(prev_pop), 0);
      ff.fifo_dout <= fbuf[n_pop % 1024];
      n_pop <= n_pop + 1;
    end
    prev_pop <= ff.fifo_rd_en;
  end

  // Reference model: words land in the shadow in push order; once all 8
  // distinct addresses are seen, that shadow snapshot is the next commit.
  bank_t      exp_q [$];
  bank_t      m_shadow = '0;
  logic [7:0] m_mask = '0;
  bank_t      act_model = '0;
  int         n_commit = 0;

  task automatic push_word(input logic [2:0] a, input logic [23:0] d);
    fbuf[n_push % 1024] = {a, d};
    n_push++;
    m_shadow[a] = d;
    m_mask[a]   = 1'b1;
    if (&m_mask) begin
      exp_q.push_back(m_shadow);
      m_mask = '0;
    end
  endtask

  always @(negedge clk) begin : mon
    bank_t e;
    bit    resume;
    if (!rst && coef_update) begin
      n_commit++;
      chk("commit_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        sweeping = 1'b1;
        for (int a = 0; a < 8; a++) begin
          sweep_addr = a[2:0];
          #1;
          chk("old_data_in_commit_cycle", 32'(coef_rd_data), 32'(act_model[a]));
        end
        resume = (n_push != n_pop);
        @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
          sweep_addr = a[2:0];
          #1;
          chk("new_data_after_commit", 32'(coef_rd_data), 32'(e[a]));
        end
        sweeping  = 1'b0;
        act_model = e;
        chk("valid_after_commit", 32'(coef_valid), 1);
        chk("update_one_cycle", 32'(coef_update), 0);
        if (resume) chk("pop_resumes_after_commit", 32'(ff.fifo_rd_en), 1);
      end
    end
  end

  task automatic wait_drain(output int cycles);
    int k = 0;
    while (n_pop != n_push && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_time", 32'(n_pop == n_push), 1);
    cycles = k;
    repeat (3) @(negedge clk);
  endtask

  task automatic strobe_commit();
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    chk("update_after_strobe", 32'(coef_update), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic probe(input string name, input logic [2:0] a, input logic [23:0] exp);
    probe_addr = a;
    #1;
    chk(name, 32'(coef_rd_data), 32'(exp));
  endtask

  initial begin
    int cyc, p0, c0, k;
    repeat (3) @(negedge clk);
    chk("reset_rd_en", 32'(ff.fifo_rd_en), 0);
    chk("reset_valid", 32'(coef_valid), 0);
    chk("reset_update", 32'(coef_update), 0);
    chk("reset_busy", 32'(load_busy), 0);
    probe("reset_active", 3'd3, 24'h0);
    rst = 1'b0;
    @(negedge clk);

    // reset mid-load: last popped word is still in flight when rst hits
    for (int a = 0; a < 4; a++) push_word(a[2:0], 24'h5A0000 + 24'(a));
    k = 0;
    while (n_pop != n_push && k < 100) begin @(negedge clk); k++; end
    chk("midload_busy", 32'(load_busy), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_busy", 32'(load_busy), 0);
    m_shadow = '0;
    m_mask   = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++) push_word(a[2:0], 24'hA0 + 24'(a));
    wait_drain(cyc);
    chk("valid_before_first_commit", 32'(coef_valid), 0);
    probe("no_stale_before_commit", 3'd3, 24'h0);
    strobe_commit();
    probe("reset_reload_a3", 3'd3, 24'hA3);

    // basic load
    p0 = n_pop;
    for (int a = 0; a < 8; a++) push_word(a[2:0], 24'h000100 + 24'(a));
    wait_drain(cyc);
    chk("basic_pop_count", 32'(n_pop - p0), 8);
    chk("basic_pop_cycles", 32'(cyc), 15);
    chk("basic_pend_busy", 32'(load_busy), 1);
    chk("basic_pend_no_pop", 32'(ff.fifo_rd_en), 0);
    strobe_commit();
    probe("basic_addr5", 3'd5, 24'h000105);
    chk("basic_valid", 32'(coef_valid), 1);

    // atomic update: 7 of 8 written, strobes must not commit
    for (int a = 0; a < 7; a++) push_word(a[2:0], 24'hFFFFFF);
    wait_drain(cyc);
    c0 = n_commit;
    for (int s = 0; s < 3; s++) begin
      sample_strobe = 1'b1;
      @(negedge clk);
      sample_strobe = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("partial_no_commit", 32'(n_commit), 32'(c0));
    probe("partial_old_data", 3'd0, 24'h000100);
    chk("partial_busy", 32'(load_busy), 1);
    push_word(3'd7, 24'hFFFFFF);
    wait_drain(cyc);
    strobe_commit();
    probe("atomic_addr4", 3'd4, 24'hFFFFFF);

    // duplicate address: last write wins, still needs all 8
    c0 = n_commit;
    push_word(3'd2, 24'h111111);
    push_word(3'd2, 24'h222222);
    for (int a = 0; a < 8; a++) if (a != 2) push_word(a[2:0], 24'($urandom));
    wait_drain(cyc);
    strobe_commit();
    chk("dup_one_commit", 32'(n_commit), 32'(c0 + 1));
    probe("dup_addr2", 3'd2, 24'h222222);

    // back-pressure: 8 complete + 4 queued, no strobe for 50 cycles
    for (int a = 0; a < 8; a++) push_word(a[2:0], 24'($urandom));
    for (int a = 0; a < 4; a++) push_word(a[2:0], 24'($urandom));
    k = 0;
    while ((n_push - n_pop) != 4 && k < 100) begin @(negedge clk); k++; end
    chk("bp_reach_pend", 32'(n_push - n_pop), 4);
    p0 = n_pop;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_no_pop_in_pend", 32'(ff.fifo_rd_en), 0);
    end
    chk("bp_fifo_held", 32'(n_pop), 32'(p0));
    chk("bp_busy", 32'(load_busy), 1);
    strobe_commit();
    wait_drain(cyc);

    // strobe coincident with the capture that completes the mask
    c0 = n_commit;
    for (int a = 4; a < 8; a++) push_word(a[2:0], 24'($urandom));
    repeat (7) @(posedge clk);
    @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (10) @(negedge clk);
    chk("coincident_no_commit", 32'(n_commit), 32'(c0));
    chk("coincident_busy", 32'(load_busy), 1);
    strobe_commit();
    chk("coincident_next_strobe", 32'(n_commit), 32'(c0 + 1));

    // random traffic with random strobes
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) push_word(3'($urandom_range(0, 7)), 24'($urandom));
      sample_strobe = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    k = 0;
    while ((exp_q.size() != 0 || n_pop != n_push) && k < 800) begin
      sample_strobe = (k % 4 == 0);
      @(negedge clk);
      k++;
    end
    sample_strobe = 1'b0;
    repeat (25) @(negedge clk);
    chk("all_commits_seen", 32'(exp_q.size()), 0);
    chk("fifo_drained", 32'(n_push - n_pop), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/filt_coef_loader.md
Name: filt_coef_loader

Overview:
- Filter-clock-domain consumer of the CPU coefficient FIFO. It pops {addr[2:0], data[23:0]} words and writes them into a shadow bank of 8 coefficients.
- When all 8 shadow entries have been written, it commits the whole shadow bank to the active bank at the next filter sample boundary. The filter therefore never computes with a mix of old and new taps.
- The active bank feeds the filter datapath through an asynchronous read port.

Parameters:
WIDTH, 24, coefficient/data width
AW, 3, coefficient address width; number of coefficients NCOEF = 2**AW = 8

Ports:
clk  input  1  filter-domain clock (same clock as the FIFO read side)
rst  input  1  reset, asynchronous, active-high
fifo_rd_empty  input  1  FIFO empty flag
fifo_dout  input  AW+WIDTH (27)  FIFO read data: [26:24] = coefficient address, [23:0] = coefficient
fifo_rd_en  output  1  FIFO pop request, one-cycle pulse
sample_strobe  input  1  one-cycle pulse marking a filter sample boundary
coef_rd_addr  input  AW  active-bank read address from the filter
coef_rd_data  output  WIDTH  active[coef_rd_addr], combinational
coef_valid  output  1  high once the first commit has occurred
coef_update  output  1  one-cycle pulse in the commit cycle
load_busy  output  1  high while a load is in progress: shadow mask != 0 or state != IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately)
  - State returns to IDLE.
  - Shadow bank, active bank and shadow mask clear to 0.
  - fifo_rd_en=0, coef_valid=0, coef_update=0, load_busy=0.
  - A FIFO word popped but not yet captured is lost. The CPU must reload all 8 coefficients.
- FIFO timing: standard FIFO with 1-cycle read latency. fifo_dout is valid on the cycle after fifo_rd_en.
- fifo_rd_en is only ever asserted while fifo_rd_empty=0. There is never a read of an empty FIFO.
- State machine, registered state:
  - IDLE: if !fifo_rd_empty, assert fifo_rd_en for that cycle and go to CAPT. Otherwise stay in IDLE.
  - CAPT: write shadow[fifo_dout[26:24]] <= fifo_dout[23:0] and set mask[addr].
    - If (mask | onehot(addr)) == 8'hFF, go to PEND.
    - Otherwise go to IDLE.
    - No pop is issued in CAPT. Throughput is one word per 2 clocks.
  - PEND: fifo_rd_en=0 (FIFO back-pressure; the CPU-side FIFO absorbs it). On sample_strobe=1, go to COMMIT. Otherwise hold.
  - COMMIT, one cycle:
    - active <= shadow for all 8 entries.
    - mask <= 0, coef_update=1, coef_valid <= 1.
    - Return to IDLE.
    - A pop may not be issued in this cycle.
- Duplicate address before completion: the shadow entry is overwritten (last write wins) and the mask is unchanged. The commit still requires all 8 distinct addresses.
- sample_strobe is ignored in IDLE and CAPT, including while a partial load is in progress. Only PEND reacts to it.
- sample_strobe in the same cycle that CAPT completes the mask: not a commit. PEND waits for the next strobe.
- Commit atomicity:
  - coef_rd_data shows the old active value up to and including the COMMIT cycle.
  - It shows the new value from the cycle after COMMIT.
  - Active-bank words are never partially updated.
- The shadow bank is not cleared by a commit. Only the mask is cleared.
- coef_update is a Moore output, high only in COMMIT.
- Widths: no arithmetic; the address is used directly as a 3-bit index and all 8 values are legal.

Test Plan:
- Reset mid-load:
  - Push addrs 0..3, assert rst for 1 cycle, then push addrs 0..7 (data 0xA0+addr), then strobe.
  - Required: coef_valid=0 until the commit; active[3]=0xA3; no stale data survives.
- Basic load:
  - Push addrs 0..7 with data 0x000100+addr, FIFO non-empty back-to-back, then pulse sample_strobe.
  - Required: fifo_rd_en pulses every other cycle (8 pulses); state PEND after the 8th capture.
  - Required: coef_update is one cycle wide, one cycle after the strobe; coef_rd_data(addr=5)=0x000105 from the next cycle; coef_valid=1.
- Atomic update:
  - After the basic load, push 7 words (addr 0..6, data 0xFFFFFF) and pulse sample_strobe 3 times.
  - Required: no commit, coef_rd_data(0)=0x000100, load_busy=1.
  - Then push addr 7 and strobe: all 8 read 0xFFFFFF.
- Duplicate address:
  - Push addr 2 = 0x111111, then addr 2 = 0x222222, then the remaining 7 addrs, then strobe.
  - Required: active[2]=0x222222; exactly one commit.
- Back-pressure:
  - Complete 8 words and keep 4 more in the FIFO while holding sample_strobe=0 for 50 cycles.
  - Required: fifo_rd_en=0 throughout PEND; popping resumes the cycle after COMMIT+1 (IDLE).
- Strobe coincidence:
  - Assert sample_strobe in the same cycle the 8th word is captured.
  - Required: no commit on that strobe; the commit occurs on the next strobe.
